// File: rtl/jk_count_ctrl.sv
// Sequencer for a JK-flip-flop counter register: drives per-bit J/K so the register
// loads a start value, counts up/down to a terminal value, then stops or wraps.

module jk_count_bit (
  input  logic q,
  input  logic n,
  output logic j,
  output logic k
);
  // J=K=1 toggles a bit that must change, J=K=0 holds one that must not.
  assign j = q ^ n;
  assign k = q ^ n;
endmodule

module jk_count_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             up_dn,
  input  logic             cont,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic             up_dn;
    logic             cont;
    logic [WIDTH-1:0] ld;
    logic [WIDTH-1:0] term;
  } cfg_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  cfg_t             cfg;
  logic [WIDTH-1:0] shadow, shadow_d, nxt, step;
  logic             shadow_we, cfg_we, err_set, err_clr;

  // Step is taken from the observed register value, not the shadow, so a
  // corrupted register keeps sequencing from where it actually is.
  assign step = cfg.up_dn ? cnt_q + ONE : cnt_q - ONE;

  always_comb begin
    state_nxt = state;
    nxt       = cnt_q;
    busy      = 1'b0;
    done      = 1'b0;
    wrap      = 1'b0;
    shadow_we = 1'b0;
    shadow_d  = shadow;
    cfg_we    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cfg_we    = 1'b1;
          err_clr   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          nxt       = cfg.ld;
          shadow_we = 1'b1;
          shadow_d  = cfg.ld;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        err_set = (cnt_q != shadow);
        if (stop) begin
          state_nxt = IDLE;
        end else if (!hold) begin
          if (cnt_q != cfg.term) begin
            nxt       = step;
            shadow_we = 1'b1;
            shadow_d  = step;
          end else if (cfg.cont) begin
            nxt       = cfg.ld;
            wrap      = 1'b1;
            shadow_we = 1'b1;
            shadow_d  = cfg.ld;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      cfg    <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (shadow_we) shadow <= shadow_d;
      if (cfg_we)    cfg    <= '{up_dn: up_dn, cont: cont, ld: ld_val, term: term_val};
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    jk_count_bit u_bit (
      .q (cnt_q[b]),
      .n (nxt[b]),
      .j (j[b]),
      .k (k[b])
    );
  end

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Bench for jk_count_ctrl: a JK register model closes the feedback loop; directed
// vector table, hand sequences, then randomized passes against a value-level model.

module tb_jk_count_ctrl;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst, start, stop, hold, up_dn, cont;
  logic [W-1:0] ld_val, term_val, cnt_q, j, k, jkreg, frc_val;
  logic         frc, busy, done, wrap, err;
  int           n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  jk_count_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .up_dn(up_dn), .cont(cont), .ld_val(ld_val), .term_val(term_val),
    .cnt_q(cnt_q), .j(j), .k(k), .busy(busy), .done(done), .wrap(wrap), .err(err)
  );

  // JK register built from jkff cells, cleared by the shared reset
  always @(posedge clk) begin
    if (rst) jkreg <= '0;
    else
      for (int b = 0; b < W; b++)
        case ({j[b], k[b]})
          2'b01:   jkreg[b] <= 1'b0;
          2'b10:   jkreg[b] <= 1'b1;
          2'b11:   jkreg[b] <= ~jkreg[b];
          default: jkreg[b] <= jkreg[b];
        endcase
  end
  assign cnt_q = frc ? frc_val : jkreg;

  typedef struct {
    logic [W-1:0] ld, term;
    logic         up;
    int           len;
    logic [W-1:0] fin;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drives an accepted start; returns sampled in the LOAD cycle.
  task automatic launch(input logic [W-1:0] l, input logic [W-1:0] t, input logic u, input logic c);
    cyc(); start = 1; ld_val = l; term_val = t; up_dn = u; cont = c; stop = 0; hold = 0; #1;
    cyc(); start = 0; ld_val = W'($urandom); term_val = W'($urandom);
    up_dn = 1'($urandom); cont = 1'($urandom); #1;
  endtask

  // Runs until done; returns number of non-done cycles seen and wrap count.
  task automatic run_to_done(output int runs, output int wraps, output logic seen);
    runs = 0; wraps = 0; seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      cyc(); #1;
      if (done) seen = 1;
      else begin runs++; if (wrap) wraps++; end
    end
  endtask

  initial begin
    int runs, wraps;
    logic seen;
    logic [W-1:0] prev, cur;
    int fin, budget;
    logic h, s;

    vecs[0] = '{ld: 2, term: 5, up: 1, len: 4, fin: 5};
    vecs[1] = '{ld: 1, term: 6, up: 0, len: 4, fin: 6};
    vecs[2] = '{ld: 5, term: 2, up: 1, len: 6, fin: 2};
    vecs[3] = '{ld: 4, term: 4, up: 1, len: 1, fin: 4};
    vecs[4] = '{ld: 0, term: 7, up: 0, len: 2, fin: 7};
    vecs[5] = '{ld: 3, term: 2, up: 1, len: 8, fin: 2};
    vecs[6] = '{ld: 6, term: 1, up: 0, len: 6, fin: 1};

    rst = 1; start = 0; stop = 0; hold = 0; up_dn = 0; cont = 0;
    ld_val = 0; term_val = 0; frc = 0; frc_val = 0;
    cyc(); cyc(); #1;
    chk("rst j", 32'(j), 0);       chk("rst k", 32'(k), 0);
    chk("rst busy", 32'(busy), 0); chk("rst done", 32'(done), 0);
    chk("rst wrap", 32'(wrap), 0); chk("rst err", 32'(err), 0);
    chk("rst cnt", 32'(cnt_q), 0);
    rst = 0;

    // single-pass table
    foreach (vecs[i]) begin
      launch(vecs[i].ld, vecs[i].term, vecs[i].up, 1'b0);
      chk("tbl load busy", 32'(busy), 1);
      cyc(); #1;
      chk("tbl first val", 32'(cnt_q), 32'(vecs[i].ld));
      chk("tbl first done", 32'(done), 0);
      run_to_done(runs, wraps, seen);
      runs++;
      chk("tbl done seen", 32'(seen), 1);
      chk("tbl pass len", 32'(runs), 32'(vecs[i].len));
      chk("tbl no wrap", 32'(wraps), 0);
      chk("tbl final", 32'(cnt_q), 32'(vecs[i].fin));
      chk("tbl done busy", 32'(busy), 0);
      cyc(); #1;
      chk("tbl idle done", 32'(done), 0);
      chk("tbl held", 32'(cnt_q), 32'(vecs[i].fin));
      chk("tbl err", 32'(err), 0);
    end

    // continuous 0..2 with wraps, then stop
    launch(0, 2, 1, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      chk("cont val", 32'(cnt_q), 32'(i % 3));
      chk("cont wrap", 32'(wrap), 32'(i % 3 == 2));
    end
    cyc(); stop = 1; #1;
    chk("stop j", 32'(j), 0); chk("stop k", 32'(k), 0); chk("stop wrap", 32'(wrap), 0);
    cyc(); stop = 0; #1;
    chk("stop busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("stop frozen", 32'(cnt_q), 0);
      chk("stop no done", 32'(done), 0);
    end

    // hold at 3 with an ignored start, then ld==term
    launch(0, 7, 1, 0);
    for (int i = 0; i < 3; i++) begin cyc(); #1; end
    for (int i = 0; i < 3; i++) begin
      cyc(); hold = 1; start = (i == 1); ld_val = 4; term_val = 4; #1;
      chk("hold cnt", 32'(cnt_q), 3); chk("hold j", 32'(j), 0); chk("hold k", 32'(k), 0);
    end
    cyc(); hold = 0; start = 0; #1;
    chk("hold release", 32'(cnt_q), 3);
    run_to_done(runs, wraps, seen);
    chk("hold done", 32'(seen), 1);
    chk("start ignored", 32'(cnt_q), 7);
    launch(4, 4, 0, 0);
    cyc(); #1;
    chk("eq cnt", 32'(cnt_q), 4); chk("eq no done yet", 32'(done), 0);
    cyc(); #1;
    chk("eq done", 32'(done), 1); chk("eq busy", 32'(busy), 0);

    // feedback corruption
    launch(0, 6, 1, 0);
    for (int i = 0; i < 3; i++) begin cyc(); #1; end
    cyc(); frc = 1; frc_val = 7; #1;
    chk("err before", 32'(err), 0);
    cyc(); frc = 0; #1;
    chk("err set", 32'(err), 1);
    run_to_done(runs, wraps, seen);
    chk("err run done", 32'(seen), 1);
    cyc(); #1;
    chk("err sticky", 32'(err), 1);
    launch(2, 3, 1, 0);
    chk("err cleared", 32'(err), 0);
    run_to_done(runs, wraps, seen);
    prev = cnt_q;
    chk("err pass final", 32'(prev), 3);

    // randomized passes against a value-level model
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] l, te;
      logic u, c;
      l = W'($urandom); te = W'($urandom); u = 1'($urandom); c = ($urandom_range(0, 2) == 0);
      launch(l, te, u, c);
      chk("rnd load busy", 32'(busy), 1);
      chk("rnd load cnt", 32'(cnt_q), 32'(prev));
      cur = l; fin = 0;
      budget = c ? $urandom_range(5, 20) : 1000;
      for (int cy = 0; cy < 100 && fin == 0; cy++) begin
        h = ($urandom_range(0, 3) == 0);
        s = (cy == budget);
        cyc(); hold = h; stop = s; #1;
        chk("rnd cnt", 32'(cnt_q), 32'(cur));
        chk("rnd busy", 32'(busy), 1);
        chk("rnd done", 32'(done), 0);
        chk("rnd wrap", 32'(wrap), 32'(!s && !h && c && cur == te));
        if (s) fin = 1;
        else if (!h) begin
          if (cur == te) begin
            if (c) cur = l; else fin = 2;
          end else cur = u ? cur + 1'b1 : cur - 1'b1;
        end
      end
      chk("rnd finished", 32'(fin != 0), 1);
      cyc(); hold = 0; stop = 0; #1;
      chk("rnd end done", 32'(done), 32'(fin == 2));
      chk("rnd end busy", 32'(busy), 0);
      chk("rnd end cnt", 32'(cnt_q), 32'(cur));
      chk("rnd err", 32'(err), 0);
      prev = cur;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
